black_jack_state_machine_module: RTL and testbench
==================================================

// Module: black_jack_state_machine_module
// PURPOSE
//  Single-deck blackjack game controller: one player versus the dealer.
//  - Draws cards from an internal 64-entry card ROM, starting at a deck base latched from addr.
//  - Deals the opening hands, serves player hit/stay requests and plays the dealer's hand.
//  - Reports win/lose/tie. Sits between debounced push-buttons and display logic.
// PARAMETERS
//  DEALER_STAND  17  dealer stands at any effective total >= this value (soft 17 included)
//  BUST_LIMIT    21  a hand with effective total > this value is bust
// PORTS
//  clk                     in   1  system clock; all state changes on its rising edge
//  reset                   in   1  asynchronous, active-low reset (0 = reset)
//  hit                     in   1  level; its rising edge starts a game or requests a card
//  stay                    in   1  level; its rising edge ends the player's turn
//  addr                    in   6  deck base (shuffle seed); latched at game start
//  data                    out  4  value of the most recently drawn card (1..10)
//  SomaDasCartasDoJogador  out  7  player effective total
//  SomaDasCartasDoDealer   out  7  dealer effective total
//  win                     out  1  player won; held until next game/reset
//  lose                    out  1  player lost; held until next game/reset
//  tie                     out  1  push; held until next game/reset
// BEHAVIOUR
//  - Reset (async, reset=0): state=IDLE, all outputs 0, sums/ace flags/pointer/edge regs 0.
//  - Card ROM: ROM[i] = min((i mod 13)+1, 10), i=0..63. Ace=1, J/Q/K=10.
//  - Draw k (k = 0,1,2.. per game) = ROM[(base + k) mod 64].
//    - k is a 6-bit counter cleared at game start; it wraps at 64.
//    - Every draw updates data on the same edge that updates the sum.
//  - Edge detect: register hit/stay each cycle; edge = input & ~prev.
//    - Stay edge takes priority over a hit edge in the same cycle; the hit edge is dropped.
//  - Effective total = raw + 10 if the hand holds an ace and raw+10 <= 21, else raw.
//    - Raw sums are 7-bit unsigned with no saturation (max raw 30).
//  - States:
//    IDLE: hit edge -> latch base=addr, k=0, clear sums and flags -> DEAL_P1.
//    DEAL_P1 -> DEAL_D1 -> DEAL_P2 -> DEAL_D2: one card per cycle, to player/dealer alternately.
//    After DEAL_D2 -> PLAYER.
//    PLAYER:
//      - player effective == 21 -> DEALER (automatic).
//      - stay edge -> DEALER.
//      - hit edge -> one card to player on the next edge.
//        - effective > 21 -> DONE, lose=1, dealer does not draw.
//        - effective == 21 -> DEALER.
//    DEALER:
//      - each cycle: dealer effective < 17 -> draw one card; else -> COMPARE.
//      - dealer bust (> 21) -> DONE, win=1.
//    COMPARE (1 cycle): player > dealer -> win, < -> lose, == -> tie; -> DONE.
//    DONE: flags and sums held; hit edge -> new game exactly as from IDLE (flags cleared).
//  - Outputs are registered.
//    - Exactly one of win/lose/tie is high in DONE; all are 0 in other states.
//  - addr changes mid-game have no effect; reset at any point aborts to IDLE immediately.
// TESTING
//  1 reset=0 while running -> all outputs 0 asynchronously; remain 0 in IDLE with no hit edge.
//  2 addr=0, hit pulse -> player 14 (A,3 soft), dealer 6, data=4.
//    Then stay -> dealer draws 5,6 -> dealer 17, lose=1.
//  3 addr=9, hit pulse -> player 20, dealer 20. Stay -> no dealer draw, tie=1.
//  4 addr=9, deal, then hit -> ace drawn, player 21, data=1.
//    Auto dealer turn -> dealer 20 -> win=1.
//  5 addr=7, deal (player 18, dealer 19), hit -> draws 10, player 28 -> lose=1; dealer stays 19.
//  6 hit and stay edges in the same cycle during PLAYER -> treated as stay.
//    Then a hit edge in DONE restarts the deal with flags cleared.

Source files
------------

// File: rtl/black_jack_state_machine_module.sv
// Single-deck blackjack controller: deals from a 64-entry card ROM starting at a
// latched deck base, serves player hit/stay, plays the dealer and reports the result.
module black_jack_state_machine_module #(
  parameter int unsigned DEALER_STAND = 17,
  parameter int unsigned BUST_LIMIT   = 21
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       hit,
  input  logic       stay,
  input  logic [5:0] addr,
  output logic [3:0] data,
  output logic [6:0] SomaDasCartasDoJogador,
  output logic [6:0] SomaDasCartasDoDealer,
  output logic       win,
  output logic       lose,
  output logic       tie
);

  typedef enum logic [3:0] {
    IDLE, DEAL_P1, DEAL_D1, DEAL_P2, DEAL_D2, PLAYER, DEALER, COMPARE, DONE
  } state_t;

  state_t     state;
  logic [5:0] base, k;
  logic [6:0] praw, draw;
  logic       pace, dace;
  logic       hit_q, stay_q;

  logic       hit_e, stay_e;
  logic [5:0] idx;
  logic [3:0] card;
  logic [6:0] p_raw_n, d_raw_n;
  logic       p_ace_n, d_ace_n;
  logic [6:0] p_eff, d_eff, p_eff_n, d_eff_n;

  function automatic logic [3:0] rom(input logic [5:0] i);
    logic [3:0] r;
    r = 4'(i % 6'd13) + 4'd1;
    return (r > 4'd10) ? 4'd10 : r;
  endfunction

  // An ace counts 11 only while that keeps the hand within the bust limit.
  function automatic logic [6:0] eff(input logic [6:0] raw, input logic ace);
    return (ace && ((raw + 7'd10) <= 7'(BUST_LIMIT))) ? raw + 7'd10 : raw;
  endfunction

  always_comb begin
    hit_e   = hit & ~hit_q;
    stay_e  = stay & ~stay_q;
    idx     = base + k;
    card    = rom(idx);
    p_raw_n = praw + {3'b000, card};
    d_raw_n = draw + {3'b000, card};
    p_ace_n = pace | (card == 4'd1);
    d_ace_n = dace | (card == 4'd1);
    p_eff   = eff(praw, pace);
    d_eff   = eff(draw, dace);
    p_eff_n = eff(p_raw_n, p_ace_n);
    d_eff_n = eff(d_raw_n, d_ace_n);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state                  <= IDLE;
      base                   <= '0;
      k                      <= '0;
      praw                   <= '0;
      draw                   <= '0;
      pace                   <= 1'b0;
      dace                   <= 1'b0;
      hit_q                  <= 1'b0;
      stay_q                 <= 1'b0;
      data                   <= '0;
      SomaDasCartasDoJogador <= '0;
      SomaDasCartasDoDealer  <= '0;
      win                    <= 1'b0;
      lose                   <= 1'b0;
      tie                    <= 1'b0;
    end else begin
      hit_q  <= hit;
      stay_q <= stay;
      case (state)
        IDLE, DONE: begin
          if (hit_e) begin
            base                   <= addr;
            k                      <= '0;
            praw                   <= '0;
            draw                   <= '0;
            pace                   <= 1'b0;
            dace                   <= 1'b0;
            SomaDasCartasDoJogador <= '0;
            SomaDasCartasDoDealer  <= '0;
            win                    <= 1'b0;
            lose                   <= 1'b0;
            tie                    <= 1'b0;
            state                  <= DEAL_P1;
          end
        end
        DEAL_P1, DEAL_P2: begin
          praw                   <= p_raw_n;
          pace                   <= p_ace_n;
          SomaDasCartasDoJogador <= p_eff_n;
          data                   <= card;
          k                      <= k + 6'd1;
          state                  <= (state == DEAL_P1) ? DEAL_D1 : DEAL_D2;
        end
        DEAL_D1, DEAL_D2: begin
          draw                  <= d_raw_n;
          dace                  <= d_ace_n;
          SomaDasCartasDoDealer <= d_eff_n;
          data                  <= card;
          k                     <= k + 6'd1;
          state                 <= (state == DEAL_D1) ? DEAL_P2 : PLAYER;
        end
        PLAYER: begin
          // Stay outranks a simultaneous hit, so the hit edge is simply dropped.
          if (p_eff == 7'(BUST_LIMIT) || stay_e) begin
            state <= DEALER;
          end else if (hit_e) begin
            praw                   <= p_raw_n;
            pace                   <= p_ace_n;
            SomaDasCartasDoJogador <= p_eff_n;
            data                   <= card;
            k                      <= k + 6'd1;
            if (p_eff_n > 7'(BUST_LIMIT)) begin
              lose  <= 1'b1;
              state <= DONE;
            end else if (p_eff_n == 7'(BUST_LIMIT)) begin
              state <= DEALER;
            end
          end
        end
        DEALER: begin
          if (d_eff < 7'(DEALER_STAND)) begin
            draw                  <= d_raw_n;
            dace                  <= d_ace_n;
            SomaDasCartasDoDealer <= d_eff_n;
            data                  <= card;
            k                     <= k + 6'd1;
            if (d_eff_n > 7'(BUST_LIMIT)) begin
              win   <= 1'b1;
              state <= DONE;
            end
          end else begin
            state <= COMPARE;
          end
        end
        COMPARE: begin
          win   <= (p_eff > d_eff);
          lose  <= (p_eff < d_eff);
          tie   <= (p_eff == d_eff);
          state <= DONE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_black_jack_state_machine_module.sv
// Directed bench for the blackjack controller; expected totals hand-derived from the card ROM.
module tb_black_jack_state_machine_module;

  logic       clk = 1'b0;
  logic       reset;
  logic       hit, stay;
  logic [5:0] addr;
  logic [3:0] data;
  logic [6:0] psum, dsum;
  logic       win, lose, tie;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  black_jack_state_machine_module #(.DEALER_STAND(17), .BUST_LIMIT(21)) dut (
    .clk(clk),
    .reset(reset),
    .hit(hit),
    .stay(stay),
    .addr(addr),
    .data(data),
    .SomaDasCartasDoJogador(psum),
    .SomaDasCartasDoDealer(dsum),
    .win(win),
    .lose(lose),
    .tie(tie)
  );

  always #5 clk = ~clk;

  // Hit pulse from IDLE/DONE, then wait out the four deal cycles.
  task automatic deal(input logic [5:0] a);
    @(negedge clk);
    addr = a;
    hit  = 1'b1;
    @(negedge clk);
    hit  = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic press_stay();
    @(negedge clk);
    stay = 1'b1;
    @(negedge clk);
    stay = 1'b0;
  endtask

  task automatic press_hit();
    @(negedge clk);
    hit = 1'b1;
    @(negedge clk);
    hit = 1'b0;
  endtask

  task automatic wait_result(input string name);
    int unsigned n;
    n = 0;
    while (!(win | lose | tie) && n < 30) begin
      @(negedge clk);
      n++;
    end
    n_checks++;
    if (!(win | lose | tie)) begin
      n_fail++;
      $display("FAIL %s timeout: no result flag after %0d cycles", name, n);
    end
  endtask

  task automatic check_hand(input string name, input logic [6:0] ep, input logic [6:0] ed,
                            input logic [3:0] edata);
    n_checks++;
    if (psum !== ep) begin
      n_fail++;
      $display("FAIL %s player: got %0d expected %0d", name, psum, ep);
    end
    n_checks++;
    if (dsum !== ed) begin
      n_fail++;
      $display("FAIL %s dealer: got %0d expected %0d", name, dsum, ed);
    end
    n_checks++;
    if (data !== edata) begin
      n_fail++;
      $display("FAIL %s data: got %0d expected %0d", name, data, edata);
    end
  endtask

  task automatic check_flags(input string name, input logic [2:0] exp_wlt);
    n_checks++;
    if ({win, lose, tie} !== exp_wlt) begin
      n_fail++;
      $display("FAIL %s flags(win,lose,tie): got %b expected %b", name, {win, lose, tie}, exp_wlt);
    end
  endtask

  task automatic test_reset();
    deal(6'd0);
    #2 reset = 1'b0;
    #1;
    n_checks++;
    if ({data, psum, dsum, win, lose, tie} !== '0) begin
      n_fail++;
      $display("FAIL reset_async: got data=%0d p=%0d d=%0d wlt=%b expected all 0",
               data, psum, dsum, {win, lose, tie});
    end
    @(negedge clk);
    reset = 1'b1;
    repeat (5) @(negedge clk);
    check_hand("reset_idle", 7'd0, 7'd0, 4'd0);
    check_flags("reset_idle", 3'b000);
  endtask

  task automatic test_stay_lose();
    @(negedge clk);
    addr = 6'd0;
    hit  = 1'b1;
    @(negedge clk);
    hit  = 1'b0;
    addr = 6'd9;  // must not disturb the latched base
    repeat (4) @(negedge clk);
    check_hand("deal_a0", 7'd14, 7'd6, 4'd4);
    check_flags("deal_a0", 3'b000);
    press_stay();
    wait_result("stay_lose");
    check_hand("stay_lose", 7'd14, 7'd17, 4'd6);
    check_flags("stay_lose", 3'b010);
    repeat (3) @(negedge clk);
    check_flags("stay_lose_hold", 3'b010);
  endtask

  task automatic test_tie();
    deal(6'd9);
    check_hand("deal_a9", 7'd20, 7'd20, 4'd10);
    press_stay();
    wait_result("tie");
    check_hand("tie", 7'd20, 7'd20, 4'd10);
    check_flags("tie", 3'b001);
  endtask

  task automatic test_hit_21();
    deal(6'd9);
    press_hit();
    check_hand("hit21", 7'd21, 7'd20, 4'd1);
    wait_result("hit21");
    check_hand("hit21_end", 7'd21, 7'd20, 4'd1);
    check_flags("hit21", 3'b100);
  endtask

  task automatic test_bust();
    deal(6'd7);
    check_hand("deal_a7", 7'd18, 7'd19, 4'd10);
    press_hit();
    wait_result("bust");
    check_hand("bust", 7'd28, 7'd19, 4'd10);
    check_flags("bust", 3'b010);
  endtask

  task automatic test_wrap();
    deal(6'd63);
    check_hand("deal_a63", 7'd12, 7'd14, 4'd3);
    press_stay();
    wait_result("wrap");
    check_hand("wrap", 7'd12, 7'd18, 4'd4);
    check_flags("wrap", 3'b010);
  endtask

  task automatic test_back_to_back();
    deal(6'd0);
    @(negedge clk);
    hit  = 1'b1;
    stay = 1'b1;
    @(negedge clk);
    hit  = 1'b0;
    stay = 1'b0;
    wait_result("hit_stay_same");
    check_hand("hit_stay_same", 7'd14, 7'd17, 4'd6);
    check_flags("hit_stay_same", 3'b010);
    @(negedge clk);
    addr = 6'd0;
    hit  = 1'b1;
    @(negedge clk);
    hit  = 1'b0;
    check_hand("restart_clear", 7'd0, 7'd0, 4'd6);
    check_flags("restart_clear", 3'b000);
    repeat (4) @(negedge clk);
    check_hand("restart_deal", 7'd14, 7'd6, 4'd4);
  endtask

  initial begin
    reset = 1'b0;
    hit   = 1'b0;
    stay  = 1'b0;
    addr  = '0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    test_reset();
    test_stay_lose();
    test_tie();
    test_hit_21();
    test_bust();
    test_wrap();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
